// File: rtl/mlp_update_seq.sv
// ---------------------------------------------------------------------------
// Module  : mlp_update_seq
// Purpose : Sequenced backprop weight-update engine for the O/X MLP; holds all
//           weights, runs an LFSR random init, then one update per start.
// Options : MLP_UPD_SAT_EN - saturating adds (default: two's-complement wrap)
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module mlp_update_seq #(
  parameter int          W     = 8,
  parameter int          N     = 8,
  parameter int          NI    = 16,
  parameter int          FRAC  = 6,
  parameter int          SH_O  = 4,
  parameter int          SH_HB = 4,
  parameter int          SH_HW = 9,
  parameter int          SH_BO = 1,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NI-1:0]         x,
  input  logic [W-1:0]          err,
  input  logic [N*(W+5)-1:0]    h_act_bus,
  output logic                  busy,
  output logic                  done,
  output logic                  init_done,
  output logic [N*W-1:0]        w_o_bus,
  output logic [W-1:0]          b_o_out,
  output logic [N*NI*W-1:0]     w_h_bus,
  output logic [N*W-1:0]        b_h_bus
);

  localparam int NW = (N > 1) ? $clog2(N) : 1;
  localparam int JW = (NI > 1) ? $clog2(NI) : 1;
  localparam int CW = 2 * W + 2;
  localparam logic [NW-1:0]        c_last_n = NW'(N - 1);
  localparam logic [JW-1:0]        c_last_j = JW'(NI - 1);
  localparam logic signed [CW-1:0] c_max    = CW'((1 << (W - 1)) - 1);
  localparam logic signed [CW-1:0] c_min    = -c_max - CW'(1);

  if (W < 4 || W > 16) begin : g_bad_w
    $error("mlp_update_seq: W must be in 4..16");
  end
  if (FRAC >= W) begin : g_bad_frac
    $error("mlp_update_seq: FRAC must be below W");
  end

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_UPD_H = 3'd2,
    S_UPD_O = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t r_state, w_state_nxt;

  logic [15:0]           r_lfsr;
  logic [NW-1:0]         r_ni;
  logic [JW-1:0]         r_nj;
  logic                  r_is_wo;
  logic [NI-1:0]         r_x;
  logic signed [W-1:0]   r_err;
  logic signed [W+4:0]   r_h_act [N];
  logic signed [W-1:0]   r_w_o   [N];
  logic signed [W-1:0]   r_b_h   [N];
  logic signed [W-1:0]   r_w_h   [N][NI];
  logic signed [W-1:0]   r_b_o;

  logic                  w_n_last;
  logic                  w_fb;
  logic signed [W-1:0]   w_lv;
  logic signed [W-1:0]   w_init;
  logic signed [2*W-1:0] w_p;
  logic signed [CW-1:0]  w_pe, w_erre, w_dhb, w_dhw, w_do, w_dbo;

  // Delta is sign-extended wide, so the sum never overflows before clamp/wrap.
  function automatic logic signed [W-1:0] f_add(input logic signed [W-1:0] a,
                                                input logic signed [CW-1:0] d);
    logic signed [CW-1:0] s;
    s = CW'(a) + d;
`ifdef MLP_UPD_SAT_EN
    if (s > c_max)      s = c_max;
    else if (s < c_min) s = c_min;
`endif
    return s[W-1:0];
  endfunction

  assign w_n_last = (r_ni == c_last_n);
  assign w_fb     = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_lv     = r_lfsr[W-1:0];
  assign w_init   = w_lv >>> 1;
  assign w_p      = r_err * r_w_o[r_ni];
  assign w_pe     = CW'(w_p);
  assign w_erre   = CW'(r_err);
  assign w_dhb    = w_pe >>> SH_HB;
  assign w_dhw    = w_pe >>> SH_HW;
  assign w_do     = (r_h_act[r_ni] > 0) ? (w_erre >>> SH_O) : '0;
  assign w_dbo    = w_erre >>> SH_BO;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_INIT;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_INIT:  if (r_is_wo && w_n_last) w_state_nxt = S_IDLE;
      S_IDLE:  if (start) w_state_nxt = S_UPD_H;
      S_UPD_H: if (w_n_last) w_state_nxt = S_UPD_O;
      S_UPD_O: w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr  <= SEED;
      r_ni    <= '0;
      r_nj    <= '0;
      r_is_wo <= 1'b0;
      r_x     <= '0;
      r_err   <= '0;
      r_b_o   <= '0;
      for (int i = 0; i < N; i++) begin
        r_h_act[i] <= '0;
        r_w_o[i]   <= '0;
        r_b_h[i]   <= '0;
        for (int j = 0; j < NI; j++) r_w_h[i][j] <= '0;
      end
    end else begin
      case (r_state)
        // Init walks w_h[i][0..NI-1] then w_o[i] for each neuron in turn.
        S_INIT: begin
          r_lfsr <= {r_lfsr[14:0], w_fb};
          if (r_is_wo) begin
            r_w_o[r_ni] <= w_init;
            r_is_wo     <= 1'b0;
            r_nj        <= '0;
            r_ni        <= w_n_last ? '0 : r_ni + NW'(1);
          end else begin
            r_w_h[r_ni][r_nj] <= w_init;
            if (r_nj == c_last_j) r_is_wo <= 1'b1;
            else                  r_nj    <= r_nj + JW'(1);
          end
        end
        S_IDLE: begin
          if (start) begin
            r_x   <= x;
            r_err <= err;
            r_ni  <= '0;
            for (int i = 0; i < N; i++) r_h_act[i] <= h_act_bus[i*(W+5) +: W+5];
          end
        end
        S_UPD_H: begin
          r_w_o[r_ni] <= f_add(r_w_o[r_ni], w_do);
          r_b_h[r_ni] <= f_add(r_b_h[r_ni], w_dhb);
          for (int j = 0; j < NI; j++)
            r_w_h[r_ni][j] <= f_add(r_w_h[r_ni][j], r_x[j] ? w_dhw : -w_dhw);
          r_ni <= w_n_last ? '0 : r_ni + NW'(1);
        end
        S_UPD_O: r_b_o <= f_add(r_b_o, w_dbo);
        default: ;
      endcase
    end
  end

  assign busy      = (r_state == S_UPD_H) || (r_state == S_UPD_O);
  assign done      = (r_state == S_DONE);
  assign init_done = (r_state != S_INIT);
  assign b_o_out   = r_b_o;

  for (genvar i = 0; i < N; i++) begin : g_bus
    assign w_o_bus[i*W +: W] = r_w_o[i];
    assign b_h_bus[i*W +: W] = r_b_h[i];
    for (genvar j = 0; j < NI; j++) begin : g_wh
      assign w_h_bus[(i*NI+j)*W +: W] = r_w_h[i][j];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mlp_update_seq.sv
// ---------------------------------------------------------------------------
// Module  : tb_mlp_update_seq
// Purpose : Self-checking bench for mlp_update_seq against an arithmetic model.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mlp_update_seq;
  localparam int W = 8, N = 8, NI = 16;
  localparam int SH_O = 4, SH_HB = 4, SH_HW = 9, SH_BO = 1;
  localparam int INIT_CYC = N * (NI + 1);

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  start = 1'b0;
  logic [NI-1:0]         x = '0;
  logic [W-1:0]          err = '0;
  logic [N*(W+5)-1:0]    h_act_bus = '0;
  logic                  busy, done, init_done;
  logic [N*W-1:0]        w_o_bus, b_h_bus;
  logic [W-1:0]          b_o_out;
  logic [N*NI*W-1:0]     w_h_bus;

  int checks = 0;
  int errors = 0;
  int m_wo[N], m_wo0[N], m_bh[N], m_wh[N][NI], m_bo, lf;

  mlp_update_seq #(.W(W), .N(N), .NI(NI), .FRAC(6), .SH_O(SH_O), .SH_HB(SH_HB),
                   .SH_HW(SH_HW), .SH_BO(SH_BO), .SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .err(err), .h_act_bus(h_act_bus),
    .busy(busy), .done(done), .init_done(init_done), .w_o_bus(w_o_bus),
    .b_o_out(b_o_out), .w_h_bus(w_h_bus), .b_h_bus(b_h_bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int fix(input int s);
`ifdef MLP_UPD_SAT_EN
    if (s > (1 << (W-1)) - 1) return (1 << (W-1)) - 1;
    if (s < -(1 << (W-1)))    return -(1 << (W-1));
    return s;
`else
    int m;
    m = s & ((1 << W) - 1);
    if (m >= (1 << (W-1))) m -= (1 << W);
    return m;
`endif
  endfunction

  function automatic int sgn(input int v, input int bits);
    int m;
    m = v & ((1 << bits) - 1);
    if (m >= (1 << (bits-1))) m -= (1 << bits);
    return m;
  endfunction

  function automatic int next_rand();
    int v, fb;
    v  = sgn(lf, W) >>> 1;
    fb = ((lf >> 15) ^ (lf >> 13) ^ (lf >> 12) ^ (lf >> 10)) & 1;
    lf = ((lf << 1) | fb) & 16'hFFFF;
    return v;
  endfunction

  task automatic model_init();
    lf = 16'hACE1;
    m_bo = 0;
    for (int i = 0; i < N; i++) begin
      m_bh[i] = 0;
      for (int j = 0; j < NI; j++) m_wh[i][j] = next_rand();
      m_wo[i]  = next_rand();
      m_wo0[i] = m_wo[i];
    end
  endtask

  task automatic model_update(input logic [NI-1:0] xv, input int e, input int h[N]);
    int p, d;
    for (int i = 0; i < N; i++) begin
      p = e * m_wo[i];
      if (h[i] > 0) m_wo[i] = fix(m_wo[i] + (e >>> SH_O));
      m_bh[i] = fix(m_bh[i] + (p >>> SH_HB));
      d = p >>> SH_HW;
      for (int j = 0; j < NI; j++) m_wh[i][j] = fix(m_wh[i][j] + (xv[j] ? d : -d));
    end
    m_bo = fix(m_bo + (e >>> SH_BO));
  endtask

  function automatic int get_wo(input int i);
    return sgn(int'(w_o_bus[i*W +: W]), W);
  endfunction

  task automatic compare_all(input string tag);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s w_o[%0d]", tag, i), get_wo(i), m_wo[i]);
      chk($sformatf("%s b_h[%0d]", tag, i), sgn(int'(b_h_bus[i*W +: W]), W), m_bh[i]);
      for (int j = 0; j < NI; j++)
        chk($sformatf("%s w_h[%0d][%0d]", tag, i, j),
            sgn(int'(w_h_bus[(i*NI+j)*W +: W]), W), m_wh[i][j]);
    end
    chk({tag, " b_o"}, sgn(int'(b_o_out), W), m_bo);
  endtask

  task automatic drive(input logic [NI-1:0] xv, input int e, input int h[N]);
    x   = xv;
    err = e[W-1:0];
    for (int i = 0; i < N; i++) h_act_bus[i*(W+5) +: W+5] = h[i][W+4:0];
  endtask

  // Counts cycles from reset release until init_done; optionally pokes start mid-init.
  task automatic wait_init(input string tag, input bit poke);
    int cnt;
    cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(posedge clk); #1;
      cnt++;
      start = poke && (cnt >= 10) && (cnt < 20);
      if (init_done) break;
    end
    start = 1'b0;
    chk({tag, " init cycles"}, cnt, INIT_CYC);
  endtask

  task automatic run_update(input string tag, input logic [NI-1:0] xv, input int e,
                            input int h[N], input bit poke);
    int nbusy, dcyc;
    nbusy = 0;
    dcyc  = -1;
    @(negedge clk);
    drive(xv, e, h);
    start = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    x         = NI'($urandom);
    err       = W'($urandom);
    h_act_bus = {N{13'($urandom)}};
    for (int k = 1; k <= 40; k++) begin
      if (busy) nbusy++;
      if (done) begin dcyc = k; break; end
      start = poke && (k == 3);
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk({tag, " busy cycles"}, nbusy, N + 1);
    chk({tag, " done cycle"}, dcyc, N + 2);
    @(posedge clk); #1;
    chk({tag, " idle after done"}, int'(busy | done), 0);
    model_update(xv, e, h);
    compare_all(tag);
  endtask

  initial begin
    int h[N];
    int pre3, pre5, bo3, d1, d2, d3, nd, cyc;
    logic [NI-1:0] xv;
    int e;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst init_done", int'(init_done), 0);
    chk("rst buses zero", int'((w_h_bus == '0) && (w_o_bus == '0) && (b_h_bus == '0) && (b_o_out == '0)), 1);

    // Random init
    model_init();
    wait_init("init1", 1'b0);
    compare_all("init1");
    for (int i = 0; i < N; i++)
      chk($sformatf("init w_o[%0d] in range", i), int'(get_wo(i) >= -64 && get_wo(i) <= 63), 1);

    // Directed: all h_act=+5, err=32
    for (int i = 0; i < N; i++) h[i] = 5;
    xv = 16'hA5C3;
    run_update("upd_h5", xv, 32, h, 1'b0);
    for (int i = 0; i < N; i++) chk($sformatf("upd_h5 w_o[%0d]+2", i), get_wo(i), m_wo0[i] + 2);
    chk("upd_h5 b_o=16", sgn(int'(b_o_out), W), 16);

    // Gated output weights on non-positive activations; start poked while busy
    h[3] = 0;
    h[5] = -7;
    pre3 = m_wo[3];
    pre5 = m_wo[5];
    run_update("upd_gate", 16'h0FF0, 32, h, 1'b1);
    chk("gate w_o[3] held", get_wo(3), pre3);
    chk("gate w_o[5] held", get_wo(5), pre5);

    // Randomised updates
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < N; i++) h[i] = int'($urandom_range(0, 40)) - 20;
      e = int'($urandom_range(0, 255)) - 128;
      run_update($sformatf("rnd%0d", t), NI'($urandom), e, h, 1'b0);
    end

    // Second reset reproduces the same initial weights
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst2 buses zero", int'((w_h_bus == '0) && (w_o_bus == '0) && (b_o_out == '0)), 1);
    model_init();
    wait_init("init2", 1'b0);
    compare_all("init2");

    // Output bias accumulation with err=127 across three updates
    for (int i = 0; i < N; i++) h[i] = 0;
    run_update("bo1", 16'h1234, 127, h, 1'b0);
    chk("bo1 value", sgn(int'(b_o_out), W), 63);
    run_update("bo2", 16'h8001, 127, h, 1'b0);
    chk("bo2 value", sgn(int'(b_o_out), W), 126);
    run_update("bo3", 16'h7FFE, 127, h, 1'b0);
`ifdef MLP_UPD_SAT_EN
    bo3 = 127;
`else
    bo3 = -67;
`endif
    chk("bo3 value", sgn(int'(b_o_out), W), bo3);

    // start held high: back-to-back updates 11 cycles apart
    for (int i = 0; i < N; i++) h[i] = int'($urandom_range(0, 10)) - 3;
    xv = NI'($urandom);
    e  = int'($urandom_range(0, 60)) - 30;
    @(negedge clk);
    drive(xv, e, h);
    start = 1'b1;
    d1 = -1; d2 = -1; d3 = -1; nd = 0; cyc = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      cyc++;
      if (done) begin
        nd++;
        if (nd == 1) d1 = cyc;
        else if (nd == 2) d2 = cyc;
        else begin d3 = cyc; start = 1'b0; break; end
      end
    end
    start = 1'b0;
    chk("held spacing 1-2", d2 - d1, 11);
    chk("held spacing 2-3", d3 - d2, 11);
    repeat (3) @(posedge clk);
    #1;
    chk("held stops", int'(busy), 0);
    for (int t = 0; t < 3; t++) model_update(xv, e, h);
    compare_all("held");

    // Reset while processing neuron 4, with start poked during the re-init
    for (int i = 0; i < N; i++) h[i] = 4;
    @(negedge clk);
    drive(16'hFFFF, 50, h);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid busy before rst", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("mid rst busy", int'(busy), 0);
    chk("mid rst init_done", int'(init_done), 0);
    chk("mid rst buses zero", int'((w_h_bus == '0) && (w_o_bus == '0) && (b_h_bus == '0) && (b_o_out == '0)), 1);
    model_init();
    wait_init("init3", 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("init3 start ignored", int'(busy | done), 0);
    compare_all("init3");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

`default_nettype wire
